sensor_monitor_ctrl: RTL

Periodic sampling controller for the 4-bit sensor bank error logic. Samples `sensors` on a programmable interval and evaluates the sensor error rule on each sample. Debounces consecutive error samples and raises a latched alarm with a captured source vector. The alarm is held until software-side logic issues a clear. Sits between the raw sensor inputs and the system fault handler.

---
 rtl/sensor_monitor_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sensor_monitor_ctrl.sv
// Periodic sensor-bank sampler with debounced, latched alarm and captured source vector.
// Optional build macro SENSOR_MASK_EN adds a sensor_mask input applied before the error rule.
module sensor_monitor_ctrl #(
   parameter int unsigned SAMPLE_DIV = 32'd4,
   parameter int unsigned DEBOUNCE   = 32'd3
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       enable,
   input  logic [3:0] sensors,
`ifdef SENSOR_MASK_EN
   input  logic [3:0] sensor_mask,
`endif
   input  logic       clear,
   output logic       sample_strobe,
   output logic       error_now,
   output logic       alarm,
   output logic [3:0] alarm_src,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_ALARM  = 2'd3
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 32'd1);
   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 32'd1);

   function automatic logic err_rule(input logic [3:0] s);
      return s[0] | (s[1] & s[2]) | (s[1] & s[3]);
   endfunction

   state_t     state_r, state_nx_s;
   logic [7:0] div_cnt_r, div_cnt_nx_s;
   logic [3:0] err_cnt_r, err_cnt_nx_s;
   logic       error_now_r, error_now_nx_s;
   logic       alarm_r, alarm_nx_s;
   logic [3:0] alarm_src_r, alarm_src_nx_s;
   logic       strobe_r, busy_r;
   logic [3:0] eff_sensors_s;
   logic       sample_err_s;

`ifdef SENSOR_MASK_EN
   assign eff_sensors_s = sensors & ~sensor_mask;
`else
   assign eff_sensors_s = sensors;
`endif
   assign sample_err_s = err_rule(eff_sensors_s);

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state, counter and alarm-capture decisions.
   always_comb begin
      state_nx_s     = state_r;
      div_cnt_nx_s   = div_cnt_r;
      err_cnt_nx_s   = err_cnt_r;
      error_now_nx_s = error_now_r;
      alarm_nx_s     = alarm_r;
      alarm_src_nx_s = alarm_src_r;
      case (state_r)
         ST_IDLE: begin
            div_cnt_nx_s = 8'd0;
            err_cnt_nx_s = 4'd0;
            if (enable) begin
               state_nx_s = ST_WAIT;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Dropping enable wins over a count that has just expired.
            if (!enable) begin
               state_nx_s   = ST_IDLE;
               div_cnt_nx_s = 8'd0;
            end else if (div_cnt_r == DIV_LAST) begin
               state_nx_s   = ST_SAMPLE;
               div_cnt_nx_s = 8'd0;
            end else begin
               div_cnt_nx_s = div_cnt_r + 8'd1;
            end
         end
         ST_SAMPLE: begin
            error_now_nx_s = sample_err_s;
            div_cnt_nx_s   = 8'd0;
            if (sample_err_s && (err_cnt_r == DEB_LAST)) begin
               state_nx_s     = ST_ALARM;
               alarm_nx_s     = 1'b1;
               alarm_src_nx_s = eff_sensors_s;
            end else begin
               if (sample_err_s) begin
                  err_cnt_nx_s = err_cnt_r + 4'd1;
               end else begin
                  err_cnt_nx_s = 4'd0;
               end
               if (enable) begin
                  state_nx_s = ST_WAIT;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
         end
         ST_ALARM: begin
            if (clear) begin
               state_nx_s     = ST_IDLE;
               alarm_nx_s     = 1'b0;
               alarm_src_nx_s = 4'd0;
               err_cnt_nx_s   = 4'd0;
            end else begin
               state_nx_s = ST_ALARM;
            end
         end
         default: begin
            state_nx_s     = ST_IDLE;
            div_cnt_nx_s   = 8'd0;
            err_cnt_nx_s   = 4'd0;
            alarm_nx_s     = 1'b0;
            alarm_src_nx_s = 4'd0;
         end
      endcase
   end

   // Datapath registers; strobe and busy are registered from the next state so they track it exactly.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         div_cnt_r   <= 8'd0;
         err_cnt_r   <= 4'd0;
         error_now_r <= 1'b0;
         alarm_r     <= 1'b0;
         alarm_src_r <= 4'd0;
         strobe_r    <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         div_cnt_r   <= div_cnt_nx_s;
         err_cnt_r   <= err_cnt_nx_s;
         error_now_r <= error_now_nx_s;
         alarm_r     <= alarm_nx_s;
         alarm_src_r <= alarm_src_nx_s;
         strobe_r    <= (state_nx_s == ST_SAMPLE);
         busy_r      <= (state_nx_s != ST_IDLE);
      end
   end

   assign sample_strobe = strobe_r;
   assign error_now     = error_now_r;
   assign alarm         = alarm_r;
   assign alarm_src     = alarm_src_r;
   assign busy          = busy_r;

   sensor_monitor_ctrl_chk #(
      .DEBOUNCE (DEBOUNCE)
   ) u_chk (
      .clk           (clk),
      .n_rst         (n_rst),
      .sample_strobe (strobe_r),
      .busy          (busy_r),
      .alarm         (alarm_r),
      .alarm_src     (alarm_src_r),
      .err_cnt       (err_cnt_r)
   );

endmodule

// Invariant checker for sensor_monitor_ctrl.
module sensor_monitor_ctrl_chk #(
   parameter int unsigned DEBOUNCE = 32'd3
) (
   input logic       clk,
   input logic       n_rst,
   input logic       sample_strobe,
   input logic       busy,
   input logic       alarm,
   input logic [3:0] alarm_src,
   input logic [3:0] err_cnt
);

   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 32'd1);

   a_strobe_busy: assert property (@(posedge clk) disable iff (!n_rst)
      sample_strobe |-> busy);

   a_strobe_single: assert property (@(posedge clk) disable iff (!n_rst)
      sample_strobe |=> !sample_strobe);

   // A raising sample always has at least one active bit, so the captured vector is never zero.
   a_alarm_src: assert property (@(posedge clk) disable iff (!n_rst)
      alarm == (alarm_src != 4'd0));

   a_err_cnt_range: assert property (@(posedge clk) disable iff (!n_rst)
      err_cnt <= DEB_LAST);

endmodule
